// File: rtl/backend_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : backend_seq_pkg
// Purpose  : Shared types and constants for the backend power sequencer.
//            Holds the sequencer state encoding, the serial frame geometry,
//            the gain field positions and small delay helper functions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package backend_seq_pkg;

  // Serial frame geometry: start bit + 5 data bits + parity bit.
  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 5;

  // Gain field positions inside the received data word.
  localparam int GA1_LSB = 0;
  localparam int GA1_W   = 2;
  localparam int GA2_LSB = 2;
  localparam int GA2_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VCO_WAIT = 3'd1,
    S_AMP_WAIT = 3'd2,
    S_RDY_WAIT = 3'd3,
    S_READY    = 3'd4
  } seq_state_t;

  // A zero delay still needs one edge to leave the state.
  function automatic int eff_dly(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/backend_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : backend_serial_rx
// Purpose  : Oversampled serial gain-frame receiver. Synchronizes i_sclk and
//            i_sdin into i_clk, detects sclk rising edges, hunts for a start
//            bit, collects 5 data bits plus even parity and guards against
//            stalled frames with an inter-edge timeout.
// Ports    : i_clk       - system clock
//            i_resetbAll - async active-low reset
//            i_sclk      - serial clock (asynchronous)
//            i_sdin      - serial data (asynchronous)
//            o_rx_valid  - one-cycle strobe, frame accepted
//            o_rx_data   - received data bits, valid with o_rx_valid
//            o_rx_err    - one-cycle strobe, parity error or timeout
// Revision : 1.0 - initial release
// ============================================================================
module backend_serial_rx
  import backend_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                 i_clk,
  input  logic                 i_resetbAll,
  input  logic                 i_sclk,
  input  logic                 i_sdin,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_err
);

  localparam int c_SYNC  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int c_TO    = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int c_GAP_W = $clog2(c_TO + 1);
  localparam int c_CNT_W = $clog2(FRAME_BITS);

  logic [c_SYNC-1:0]    r_sclk_sync;
  logic [c_SYNC-1:0]    r_sdin_sync;
  logic                 r_sclk_prev;
  logic                 r_busy;
  logic [c_CNT_W-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_data;
  logic [c_GAP_W-1:0]   r_gap;
  logic                 r_valid;
  logic                 r_err;

  logic w_sclk;
  logic w_sdin;
  logic w_rise;

  assign w_sclk = r_sclk_sync[c_SYNC-1];
  assign w_sdin = r_sdin_sync[c_SYNC-1];
  assign w_rise = w_sclk & ~r_sclk_prev;

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_sclk_sync <= '0;
      r_sdin_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[c_SYNC-2:0], i_sclk};
      r_sdin_sync <= {r_sdin_sync[c_SYNC-2:0], i_sdin};
      r_sclk_prev <= w_sclk;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_gap     <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (!r_busy) begin
        // Hunt: zeros are ignored, a sampled one is the start bit.
        r_gap <= '0;
        if (w_rise && w_sdin) begin
          r_busy    <= 1'b1;
          r_bit_cnt <= c_CNT_W'(1);
        end
      end else if (w_rise) begin
        r_gap <= '0;
        if (r_bit_cnt == c_CNT_W'(FRAME_BITS - 1)) begin
          // Parity sample: data plus parity must XOR to zero.
          r_busy    <= 1'b0;
          r_bit_cnt <= '0;
          if ((^r_data ^ w_sdin) == 1'b0) begin
            r_valid <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          // Shift in from the top so the first data bit ends up in bit 0.
          r_data    <= {w_sdin, r_data[DATA_BITS-1:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else if (r_gap == c_GAP_W'(c_TO - 1)) begin
        r_busy    <= 1'b0;
        r_bit_cnt <= '0;
        r_gap     <= '0;
        r_err     <= 1'b1;
      end else begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

  assign o_rx_valid = r_valid;
  assign o_rx_data  = r_data;
  assign o_rx_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/backend_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : backend_power_sequencer
// Purpose  : Backend configuration and power-up sequencer. Latches amplifier
//            gain codes from serial frames and releases VCO reset, amplifier
//            resets and the ready flag after programmable i_clk delays.
//            Accepts reconfiguration while running.
// Ports    : i_clk       - system clock
//            i_resetbAll - async active-low reset
//            i_sclk      - serial clock (asynchronous)
//            i_sdin      - serial data
//            o_ready     - backend ready
//            o_resetb1   - amplifier 1 reset, active-low
//            o_gainA1    - amplifier 1 gain code
//            o_resetb2   - amplifier 2 reset, active-low
//            o_gainA2    - amplifier 2 gain code
//            o_resetbvco - VCO reset, active-low
//            o_frame_err - one-cycle pulse on rejected frame
// Revision : 1.0 - initial release
// ============================================================================
module backend_power_sequencer
  import backend_seq_pkg::*;
#(
  parameter int VCO_DLY     = 2,
  parameter int AMP_DLY     = 10,
  parameter int RDY_DLY     = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             i_clk,
  input  logic             i_resetbAll,
  input  logic             i_sclk,
  input  logic             i_sdin,
  output logic             o_ready,
  output logic             o_resetb1,
  output logic [GA1_W-1:0] o_gainA1,
  output logic             o_resetb2,
  output logic [GA2_W-1:0] o_gainA2,
  output logic             o_resetbvco,
  output logic             o_frame_err
);

  localparam int c_VCO_EFF = eff_dly(VCO_DLY);
  localparam int c_AMP_EFF = eff_dly(AMP_DLY);
  localparam int c_RDY_EFF = eff_dly(RDY_DLY);
  localparam int c_MAX     = max3(c_VCO_EFF, c_AMP_EFF, c_RDY_EFF);
  localparam int c_CNT_W   = (c_MAX > 1) ? $clog2(c_MAX) : 1;

  // Counter is loaded with delay-1 on entry; leaving happens on the edge
  // that sees it at zero, so the output moves exactly DLY edges later.
  localparam logic [c_CNT_W-1:0] c_VCO_LOAD = c_CNT_W'(c_VCO_EFF - 1);
  localparam logic [c_CNT_W-1:0] c_AMP_LOAD = c_CNT_W'(c_AMP_EFF - 1);
  localparam logic [c_CNT_W-1:0] c_RDY_LOAD = c_CNT_W'(c_RDY_EFF - 1);

  logic                 w_rx_valid;
  logic [DATA_BITS-1:0] w_rx_data;
  logic                 w_rx_err;

  seq_state_t           r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_ready;
  logic                 r_resetb_amp;
  logic                 r_resetbvco;
  logic [GA1_W-1:0]     r_gainA1;
  logic [GA2_W-1:0]     r_gainA2;
  logic                 r_frame_err;

  backend_serial_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_resetbAll (i_resetbAll),
    .i_sclk      (i_sclk),
    .i_sdin      (i_sdin),
    .o_rx_valid  (w_rx_valid),
    .o_rx_data   (w_rx_data),
    .o_rx_err    (w_rx_err)
  );

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_resetb_amp <= 1'b0;
      r_resetbvco  <= 1'b0;
      r_gainA1     <= '0;
      r_gainA2     <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= w_rx_err;
      if (w_rx_valid) begin
        r_gainA1 <= w_rx_data[GA1_LSB +: GA1_W];
        r_gainA2 <= w_rx_data[GA2_LSB +: GA2_W];
        case (r_state)
          S_IDLE, S_VCO_WAIT: begin
            r_state <= S_VCO_WAIT;
            r_cnt   <= c_VCO_LOAD;
          end
          default: begin
            // Reconfig: VCO keeps running, amplifiers re-sequence.
            r_state      <= S_AMP_WAIT;
            r_cnt        <= c_AMP_LOAD;
            r_resetb_amp <= 1'b0;
            r_ready      <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          S_VCO_WAIT: begin
            if (r_cnt == '0) begin
              r_resetbvco <= 1'b1;
              r_state     <= S_AMP_WAIT;
              r_cnt       <= c_AMP_LOAD;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_AMP_WAIT: begin
            if (r_cnt == '0) begin
              r_resetb_amp <= 1'b1;
              r_state      <= S_RDY_WAIT;
              r_cnt        <= c_RDY_LOAD;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_RDY_WAIT: begin
            if (r_cnt == '0) begin
              r_ready <= 1'b1;
              r_state <= S_READY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_resetb1   = r_resetb_amp;
  assign o_resetb2   = r_resetb_amp;
  assign o_resetbvco = r_resetbvco;
  assign o_gainA1    = r_gainA1;
  assign o_gainA2    = r_gainA2;
  assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_backend_power_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_backend_power_sequencer
// Purpose  : Directed self-checking bench for backend_power_sequencer.
//            Expected gains are queued when a valid frame is sent and popped
//            when the DUT latches new gains; sequencing delays are measured
//            relative to that latch edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_backend_power_sequencer;

  typedef struct packed {
    logic [1:0] a1;
    logic [2:0] a2;
  } gains_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       sdin;
  logic       o_ready;
  logic       o_resetb1;
  logic [1:0] o_gainA1;
  logic       o_resetb2;
  logic [2:0] o_gainA2;
  logic       o_resetbvco;
  logic       o_frame_err;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     last_rise_cyc = 0;
  gains_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  backend_power_sequencer dut (
    .i_clk       (clk),
    .i_resetbAll (rst_n),
    .i_sclk      (sclk),
    .i_sdin      (sdin),
    .o_ready     (o_ready),
    .o_resetb1   (o_resetb1),
    .o_gainA1    (o_gainA1),
    .o_resetb2   (o_resetb2),
    .o_gainA2    (o_gainA2),
    .o_resetbvco (o_resetbvco),
    .o_frame_err (o_frame_err)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic gains_t cur_gains();
    return {o_gainA1, o_gainA2};
  endfunction

  // Frame vector f[6] is sent first: start, gA1[0], gA1[1], gA2[0..2], parity.
  function automatic gains_t frame_gains(input logic [6:0] f);
    gains_t g;
    g.a1 = {f[4], f[5]};
    g.a2 = {f[1], f[2], f[3]};
    return g;
  endfunction

  function automatic logic pick(input int which);
    case (which)
      0:       return o_resetbvco;
      1:       return o_resetb1;
      2:       return o_ready;
      default: return o_frame_err;
    endcase
  endfunction

  // Called at a negedge; sclk period is 6 clk, 3 low then 3 high.
  task automatic send_bit(input logic b);
    sclk = 1'b0;
    sdin = b;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    last_rise_cyc = cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] f);
    for (int i = 6; i >= 0; i--) send_bit(f[i]);
    sclk = 1'b0;
    // Only frames with good even parity are expected to be accepted.
    if ((^f[5:0]) == 1'b0) sb_q.push_back(frame_gains(f));
  endtask

  // Waits for a signal to go high; dt is cycles since t0, -1 on timeout.
  task automatic wait_sig(input int which, input int t0, input int budget, output int dt);
    dt = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pick(which) === 1'b1) begin
        dt = cyc - t0;
        break;
      end
    end
  endtask

  // mode 0: gains only, 1: power-up sequence, 2: reconfig sequence
  task automatic accept_check(input string tag, input gains_t prev, input int mode);
    bit     seen;
    int     t0;
    int     dt;
    gains_t exp;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cur_gains() !== prev) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_accept_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    t0 = cyc;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_gains"}, 32'(cur_gains()), 32'(exp));
    end else begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end
    if (mode == 1) begin
      check({tag, "_outs_at_accept"}, {28'd0, o_resetbvco, o_resetb1, o_resetb2, o_ready}, 32'd0);
      wait_sig(0, t0, 50, dt);
      check({tag, "_vco_dly"}, 32'(dt), 32'd2);
      wait_sig(1, t0, 50, dt);
      check({tag, "_amp_dly"}, 32'(dt), 32'd12);
      check({tag, "_rb2_with_rb1"}, 32'(o_resetb2), 32'd1);
      check({tag, "_rdy_low_at_amp"}, 32'(o_ready), 32'd0);
      wait_sig(2, t0, 50, dt);
      check({tag, "_rdy_dly"}, 32'(dt), 32'd22);
    end else if (mode == 2) begin
      check({tag, "_outs_at_reconf"}, {28'd0, o_resetbvco, o_resetb1, o_resetb2, o_ready}, 32'b1000);
      wait_sig(1, t0, 50, dt);
      check({tag, "_amp_dly"}, 32'(dt), 32'd10);
      check({tag, "_rb2_with_rb1"}, 32'(o_resetb2), 32'd1);
      check({tag, "_vco_held"}, 32'(o_resetbvco), 32'd1);
      wait_sig(2, t0, 50, dt);
      check({tag, "_rdy_dly"}, 32'(dt), 32'd20);
    end
  endtask

  initial begin
    gains_t prev;
    int     dt;
    bit     changed;
    logic [10:0] snap;

    rst_n = 1'b0;
    sclk  = 1'b0;
    sdin  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", {21'd0, o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2,
                         o_resetbvco, o_frame_err}, 32'd0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_outs", {21'd0, o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2,
                              o_resetbvco, o_frame_err}, 32'd0);

    // Bad parity frame: one error pulse, nothing else moves.
    send_frame(7'b1100110);
    wait_sig(3, cyc, 40, dt);
    check("perr_seen", 32'(dt >= 0), 32'd1);
    @(negedge clk);
    check("perr_one_cycle", 32'(o_frame_err), 32'd0);
    repeat (20) @(negedge clk);
    check("perr_outs_idle", {21'd0, o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2,
                             o_resetbvco, o_frame_err}, 32'd0);

    // Power-up frame
    prev = cur_gains();
    send_frame(7'b1100111);
    accept_check("pwrup", prev, 1);
    check("pwrup_gains_lit", 32'(cur_gains()), 32'({2'b01, 3'b110}));

    // Reconfig while ready
    repeat (5) @(negedge clk);
    prev = cur_gains();
    send_frame(7'b1011110);
    accept_check("reconf", prev, 2);
    check("reconf_gains_lit", 32'(cur_gains()), 32'({2'b10, 3'b111}));

    // Timeout: three bits then a long idle gap.
    repeat (5) @(negedge clk);
    prev = cur_gains();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    sclk = 1'b0;
    wait_sig(3, last_rise_cyc, 80, dt);
    check("tmo_err_late_enough", 32'(dt >= 64), 32'd1);
    check("tmo_err_not_too_late", 32'(dt >= 0 && dt <= 72), 32'd1);
    @(negedge clk);
    check("tmo_err_one_cycle", 32'(o_frame_err), 32'd0);
    repeat (10) @(negedge clk);
    check("tmo_gains_kept", 32'(cur_gains()), 32'(prev));
    check("tmo_ready_kept", 32'(o_ready), 32'd1);

    // A full valid frame after the timeout is accepted.
    prev = cur_gains();
    send_frame(7'b1110000);
    accept_check("post_tmo", prev, 2);

    // Async reset in the middle of amplifier wait.
    repeat (3) @(negedge clk);
    prev = cur_gains();
    send_frame(7'b1010100);
    accept_check("rst_mid", prev, 0);
    repeat (4) @(negedge clk);
    check("rst_mid_vco_before", 32'(o_resetbvco), 32'd1);
    check("rst_mid_amp_before", 32'(o_resetb1), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outs_now", {21'd0, o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2,
                               o_resetbvco, o_frame_err}, 32'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    changed = 1'b0;
    snap = {o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2, o_resetbvco, o_frame_err};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({o_ready, o_resetb1, o_gainA1, o_resetb2, o_gainA2, o_resetbvco, o_frame_err} !== snap)
        changed = 1'b1;
    end
    check("rst_release_quiet", 32'(changed), 32'd0);

    // Leading zeros are ignored by the hunt.
    prev = cur_gains();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_frame(7'b1111010);
    accept_check("hunt", prev, 1);
    check("hunt_gains_lit", 32'(cur_gains()), 32'({2'b11, 3'b101}));

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
